// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state type, the data/byte-enable widths and the wait-counter width helper.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } state_e;

    function automatic int unsigned wait_cnt_w(input int unsigned wait_cycles);
        int unsigned w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with synchronous byte-enabled write and registered read; no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [BE_W-1:0]       be,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WORD_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits a fixed number of cycles,
// performs the access on a local array and returns data and status on a response channel.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned CNT_W = wait_cnt_w(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_e                state;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  write_q;
    logic [WORD_W-1:0]     addr_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [BE_W-1:0]       be_q;

    logic                  addr_err;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  arr_we;
    logic [WORD_W-1:0]     arr_rdata;

    always_comb begin
        addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != '0);
        word_idx = addr_q[ADDR_WIDTH+1:2];
        // Read from the incoming address while idle so a zero-wait access has its word ready.
        rd_idx   = (state == StIdle) ? req_addr[ADDR_WIDTH+1:2] : word_idx;
        arr_we   = (state == StAccess) && write_q && !addr_err;
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (be_q),
        .waddr (word_idx),
        .wdata (wdata_q),
        .raddr (rd_idx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            wait_cnt  <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        be_q      <= req_be;
                        req_ready <= 1'b0;
                        state     <= (WAIT_CYCLES == 0) ? StAccess : StWait;
                    end
                end
                StWait: begin
                    if (wait_cnt == CNT_LAST) begin
                        wait_cnt <= '0;
                        state    <= StAccess;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StAccess: begin
                    rsp_err   <= addr_err;
                    rsp_rdata <= (write_q || addr_err) ? '0 : arr_rdata;
                    rsp_valid <= 1'b1;
                    state     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: unit 0 uses two wait states, unit 1 uses none.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    exp_t        exp_q[$];
    logic [31:0] mdl [2][256];
    int          tot = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_WIDTH  (8),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_write (req_write[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .req_be    (req_be[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    dmem_responder #(
        .ADDR_WIDTH  (8),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_write (req_write[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .req_be    (req_be[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    endfunction

    // Expected response is computed from the bench model when the request is accepted.
    function automatic exp_t model_access(input int u, input logic w, input logic [31:0] a,
                                          input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        e.err   = addr_bad(a);
        e.rdata = 32'd0;
        if (!e.err) begin
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mdl[u][a[9:2]][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                e.rdata = mdl[u][a[9:2]];
            end
        end
        return e;
    endfunction

    task automatic send(input int u, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        req_valid[u] = 1'b1;
        req_write[u] = w;
        req_addr[u]  = a;
        req_wdata[u] = d;
        req_be[u]    = be;
        while (req_ready[u] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        tot++;
        if (req_ready[u] !== 1'b1) begin
            bad++;
            $display("FAIL accept u=%0d addr=%h: req_ready=%b, required 1", u, a, req_ready[u]);
        end
        exp_q.push_back(model_access(u, w, a, d, be));
        @(posedge clk); #1;
        req_valid[u] = 1'b0;
    endtask

    task automatic recv(input int u, input int exp_lat, input string tag);
        exp_t e;
        int   lat = 1;
        rsp_ready[u] = 1'b1;
        while (rsp_valid[u] !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        tot++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: response with empty scoreboard", tag);
        end else if (rsp_valid[u] !== 1'b1) begin
            bad++;
            void'(exp_q.pop_front());
            $display("FAIL %s rsp_timeout: rsp_valid=%b, required 1", tag, rsp_valid[u]);
        end else begin
            e = exp_q.pop_front();
            if (rsp_rdata[u] !== e.rdata) begin
                bad++;
                $display("FAIL %s rdata: got %h, required %h", tag, rsp_rdata[u], e.rdata);
            end
            tot++;
            if (rsp_err[u] !== e.err) begin
                bad++;
                $display("FAIL %s err: got %b, required %b", tag, rsp_err[u], e.err);
            end
            if (exp_lat > 0) begin
                tot++;
                if (lat != exp_lat) begin
                    bad++;
                    $display("FAIL %s latency: got %0d, required %0d", tag, lat, exp_lat);
                end
            end
            @(posedge clk); #1;
            tot++;
            if (rsp_valid[u] !== 1'b0) begin
                bad++;
                $display("FAIL %s rsp_drop: rsp_valid=%b, required 0", tag, rsp_valid[u]);
            end
        end
        rsp_ready[u] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            tot++;
            if ({req_ready[u], rsp_valid[u], rsp_err[u], rsp_rdata[u]} !== {3'b100, 32'd0}) begin
                bad++;
                $display("FAIL reset u=%0d: ready=%b valid=%b err=%b rdata=%h, required 1 0 0 0",
                         u, req_ready[u], rsp_valid[u], rsp_err[u], rsp_rdata[u]);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        send(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        recv(0, 4, "store_full");
        send(0, 1'b0, 32'h10, 32'h0, 4'h0);
        recv(0, 4, "load_full");
    endtask

    task automatic test_byte_enable();
        send(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
        recv(0, 4, "store_be1");
        send(0, 1'b0, 32'h10, 32'h0, 4'hF);
        recv(0, 0, "load_be1");
        send(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
        recv(0, 0, "store_be0");
        send(0, 1'b0, 32'h10, 32'h0, 4'h0);
        recv(0, 0, "load_be0");
    endtask

    task automatic test_errors();
        send(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
        recv(0, 0, "store_w0");
        send(0, 1'b0, 32'h13, 32'h0, 4'h0);
        recv(0, 0, "load_misaligned");
        send(0, 1'b1, 32'h400, 32'h12345678, 4'hF);
        recv(0, 0, "store_range");
        send(0, 1'b0, 32'h0, 32'h0, 4'h0);
        recv(0, 0, "load_w0_intact");
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n = 0;
        send(0, 1'b0, 32'h0, 32'h0, 4'h0);
        // Second request is held valid while the first response is stalled.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h10;
        req_be[0]    = 4'h0;
        rsp_ready[0] = 1'b0;
        while (rsp_valid[0] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        e = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            tot++;
            if ({rsp_valid[0], rsp_err[0], req_ready[0], rsp_rdata[0]} !== {1'b1, e.err, 1'b0, e.rdata})
            begin
                bad++;
                $display("FAIL hold c=%0d: valid=%b err=%b ready=%b rdata=%h, required 1 %b 0 %h",
                         c, rsp_valid[0], rsp_err[0], req_ready[0], rsp_rdata[0], e.err, e.rdata);
            end
            @(posedge clk); #1;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        tot++;
        if ({rsp_valid[0], req_ready[0]} !== 2'b01) begin
            bad++;
            $display("FAIL release: valid=%b ready=%b, required 0 1", rsp_valid[0], req_ready[0]);
        end
        exp_q.push_back(model_access(0, 1'b0, 32'h10, 32'h0, 4'h0));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        tot++;
        if (req_ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL second_accept: req_ready=%b, required 0", req_ready[0]);
        end
        recv(0, 4, "second_load");
    endtask

    task automatic test_zero_wait();
        send(1, 1'b1, 32'h0, 32'h01020304, 4'hF);
        recv(1, 2, "w0_store0");
        send(1, 1'b1, 32'h4, 32'hA0B0C0D0, 4'hF);
        recv(1, 2, "w0_store4");
        send(1, 1'b0, 32'h4, 32'h0, 4'h0);
        recv(1, 2, "w0_load4");
        rsp_ready[1] = 1'b1;
        fork
            begin
                send(1, 1'b0, 32'h0, 32'h0, 4'h0);
                send(1, 1'b0, 32'h4, 32'h0, 4'h0);
            end
            begin
                recv(1, 0, "b2b_load0");
                recv(1, 0, "b2b_load4");
            end
        join
        rsp_ready[1] = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        send(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        recv(0, 4, "pre_store20");
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hFFFFFFFF;
        req_be[0]    = 4'hF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        tot++;
        if (req_ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL midop_accept: req_ready=%b, required 0", req_ready[0]);
        end
        reset = 1'b1;
        #1;
        tot++;
        if ({req_ready[0], rsp_valid[0], rsp_err[0], rsp_rdata[0]} !== {3'b100, 32'd0}) begin
            bad++;
            $display("FAIL midop_reset: ready=%b valid=%b err=%b rdata=%h, required 1 0 0 0",
                     req_ready[0], rsp_valid[0], rsp_err[0], rsp_rdata[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        tot++;
        if ({rsp_valid[0], req_ready[0]} !== 2'b01) begin
            bad++;
            $display("FAIL midop_idle: valid=%b ready=%b, required 0 1", rsp_valid[0], req_ready[0]);
        end
        send(0, 1'b0, 32'h20, 32'h0, 4'h0);
        recv(0, 4, "post_reset_load20");
    endtask

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_write[u] = 1'b0;
            req_addr[u]  = 32'd0;
            req_wdata[u] = 32'd0;
            req_be[u]    = 4'd0;
            rsp_ready[u] = 1'b0;
        end
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_zero_wait();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
